// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side blocks: default widths and the
// skid-buffer state encoding. The state encoding equals the number of words
// held, so the state register doubles as the level output.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// ---------------------------------------------------------------------------
// fifo_rd_skid_buf
// Two-entry skid buffer between the FIFO memory read port and the consumer.
// The head register is the output register; the tail register catches the
// second word when the consumer stalls.
//
// Ports:
//   clk, rst_n  read-domain clock, asynchronous active-low reset
//   clear       synchronous flush (drops both entries)
//   wr_en       write a word returned by memory
//   wr_data     word returned by memory
//   pop         consumer takes the head word this cycle
//   m_valid     head word available
//   m_data      head (oldest) word, registered
//   level       number of words held (0..2)
// ---------------------------------------------------------------------------
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            level
);

    buf_state_t            state;
    buf_state_t            state_next;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  load_head_wr;
    logic                  load_head_tail;
    logic                  load_tail;

    // Next-state and register-load selection. A new word goes straight to
    // the head whenever the head is free (or being popped); otherwise it is
    // parked in the tail and promoted on the next pop.
    always_comb begin
        state_next     = state;
        load_head_wr   = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        if (clear) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (wr_en) begin
                        state_next   = ONE;
                        load_head_wr = 1'b1;
                    end
                end
                ONE: begin
                    if (wr_en && pop) begin
                        load_head_wr = 1'b1;
                    end else if (wr_en) begin
                        state_next = TWO;
                        load_tail  = 1'b1;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // The issue logic never lets a write land here; the
                    // write+pop case is still handled so data is never lost.
                    if (pop) begin
                        load_head_tail = 1'b1;
                        if (wr_en) begin
                            load_tail = 1'b1;
                        end else begin
                            state_next = ONE;
                        end
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // State and storage registers; storage resets to zero so m_data is zero
    // while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_next;
            if (load_head_wr) begin
                head <= wr_data;
            end else if (load_head_tail) begin
                head <= tail;
            end
            if (load_tail) begin
                tail <= wr_data;
            end
        end
    end

    // A write into a full buffer without a pop would overwrite data.
    always @(posedge clk) begin
        if (rst_n && !clear) begin
            assert (!(state == TWO && wr_en && !pop));
        end
    end

    assign m_valid = (state != EMPTY);
    assign m_data  = head;
    assign level   = state;

endmodule

// File: rtl/fifo_rd_prefetch.sv
// ---------------------------------------------------------------------------
// fifo_rd_prefetch
// Read-side prefetcher for a synchronous FIFO. Issues memory reads ahead of
// the consumer so that a registered output can sustain one word per cycle
// despite the one-cycle memory read latency.
//
// Ports:
//   clk, rst_n  read-domain clock, asynchronous active-low reset
//   clear       synchronous flush shared with the read pointer control
//   fifo_empty  read-side empty flag from pointer control
//   fifo_inc    read-pointer increment / memory read enable
//   mem_rdata   memory data, valid the cycle after fifo_inc
//   m_valid     output word available
//   m_ready     consumer accepts the word
//   m_data      output word (registered)
//   level       words held in the skid buffer (0..2)
// ---------------------------------------------------------------------------
module fifo_rd_prefetch
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  fifo_empty,
    output logic                  fifo_inc,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            level
);

    logic       inflight;
    logic       pop;
    logic       wr_en;
    logic [2:0] occupancy;

    // Occupancy counts words already buffered plus the one returning from
    // memory, minus the one leaving now. Reading only while it is below two
    // guarantees a free slot for every returning word.
    assign pop       = m_valid & m_ready;
    assign occupancy = {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_inc  = rst_n & ~clear & ~fifo_empty & (occupancy < 3'd2);

    // A word returning during a flush belongs to the old stream and is dropped.
    assign wr_en = inflight & ~clear;

    // inflight marks the cycle in which mem_rdata carries a requested word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_inc;
        end
    end

    // The address width only has to be a legal pointer width here.
    always @(posedge clk) begin
        assert (ADDR_WIDTH > 0);
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_data (mem_rdata),
        .pop     (pop),
        .m_valid (m_valid),
        .m_data  (m_data),
        .level   (level)
    );

endmodule

// File: doc/fifo_rd_prefetch.md
FIFO_RD_PREFETCH -- requirements
Module: fifo_rd_prefetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the read data width.
REQ-002 Parameter ADDR_WIDTH, default 5, sets the FIFO address width and exists for package consistency only.
REQ-003 clk  input  1  read-domain clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous flush, shared with the read-side pointer control.
REQ-006 fifo_empty  input  1  read-side empty flag from pointer control.
REQ-007 fifo_inc  output  1  read-increment pulse to pointer control; also the memory read enable.
REQ-008 mem_rdata  input  DATA_WIDTH  memory read data, valid exactly 1 cycle after fifo_inc.
REQ-009 m_valid  output  1  output word available.
REQ-010 m_ready  input  1  consumer accepts the word.
REQ-011 m_data  output  DATA_WIDTH  output word, driven from a register.
REQ-012 level  output  2  number of words held in the skid buffer (0..2).

Function
REQ-013 Words shall leave on m_data in exactly the order they were read from memory, with no loss or duplication.
REQ-014 pop = m_valid & m_ready; a word transfers only on a cycle where pop is high.
REQ-015 inflight shall be a 1-bit register that is set the cycle after fifo_inc=1 and otherwise cleared.
REQ-016 fifo_inc shall be 1 iff !clear & !fifo_empty & (level + inflight - pop) < 2.
REQ-017 fifo_inc shall be combinational from fifo_empty, clear, m_ready and registered state only.
REQ-018 When inflight=1 and clear=0, mem_rdata shall be written into the buffer at the clock edge ending that cycle.
REQ-019 Buffer FSM states are EMPTY (level 0), ONE (level 1) and TWO (level 2).
REQ-020 EMPTY transitions to ONE on a write; otherwise it holds.
REQ-021 ONE transitions to TWO on a write without pop, to EMPTY on pop without write, and holds on write+pop or on neither.
REQ-022 TWO transitions to ONE on pop.
REQ-023 A write while in TWO without pop is impossible by REQ-016 and shall be flagged by an assertion.
REQ-024 m_valid shall be 1 iff level != 0.
REQ-025 m_data shall present the oldest buffered word.
REQ-026 m_data shall be stable while m_valid=1 and m_ready=0.
REQ-027 Latency: the first word after fifo_empty falls (buffer EMPTY) shall see fifo_inc in cycle 0 and m_valid in cycle 2.
REQ-028 Throughput: sustained one word per cycle when m_ready=1 and fifo_empty=0.
REQ-029 Backpressure: with m_ready=0 and fifo_empty=0, at most 2 reads shall be issued, after which fifo_inc=0 until a pop.
REQ-030 When clear=1, the next state shall be level=0, inflight=0 and m_valid=0.
REQ-031 Data returning for a read issued before clear shall be discarded.
REQ-032 When clear=1, fifo_inc shall be 0.
REQ-033 A pop in the same cycle as clear shall not be reported as an extra transfer.
REQ-034 When fifo_empty rises while a read is in flight, the in-flight word shall still be captured.

Reset
REQ-035 rst_n=0 shall asynchronously force level=0, inflight=0, m_valid=0, fifo_inc=0 and m_data=0.
REQ-036 Buffer storage shall reset to 0.
REQ-037 Reset deassertion mid-operation shall resume from the EMPTY state, with no spurious fifo_inc in the first cycle unless fifo_empty=0.

Structure
REQ-038 A shared package fifo_pkg shall hold the DATA_WIDTH/ADDR_WIDTH defaults and the buffer state enumeration {EMPTY, ONE, TWO}.
REQ-039 One sub-module, fifo_rd_skid_buf, shall implement the 2-entry storage, head/tail select and level logic.
REQ-040 The top level shall contain only issue logic, inflight tracking and clear handling.

Verification
REQ-041 Single word: fifo_empty low for one read, m_ready=1, data 0xA5A5_0001 -> fifo_inc in cycle 0, m_valid=1 with m_data=0xA5A5_0001 in cycle 2, level back to 0 in cycle 3.
REQ-042 Streaming: 32 words 0..31, m_ready=1 -> fifo_inc high for 32 consecutive cycles; outputs 0..31 in order on consecutive cycles.
REQ-043 Backpressure: m_ready=0, 10 words available -> exactly 2 fifo_inc pulses, level=2, m_data=word0 held; m_ready=1 -> remaining words drain in order at 1 per cycle.
REQ-044 Clear with a read in flight: clear=1 in the cycle after fifo_inc -> level=0, m_valid=0 next cycle, and the returning word never appears on m_data.
REQ-045 Empty race: fifo_empty rises in the cycle after fifo_inc -> the in-flight word is delivered and no further fifo_inc is issued.
REQ-046 Reset mid-stream: rst_n pulsed low with level=2 -> all outputs are 0 immediately; after release the stream restarts in order from the next memory word.
